ram_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port `ram` block between the instruction-fetch unit (read-only) and the load/store unit (read/write).
- Accepts at most one access per cycle, registers it into a one-stage access pipeline and drives the RAM control/address/data pins from that stage.
- Returns registered read data with fixed latency.
- Sits between the CPU core and the RAM instance.

---
 rtl/ram_arbiter_if.sv | 39 +++
 rtl/ram_arbiter.sv | 108 ++++++++++
 tb/tb_ram_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// CPU-side request/response signals and RAM pins of the ram_arbiter, bundled as one interface.
// The slave modport is the arbiter's view; the master modport is the core/RAM environment's view.
interface ram_arbiter_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 f_req;
  logic [ADDR_BITS-1:0] f_addr;
  logic                 f_gnt;
  logic                 f_rvalid;
  logic [DATA_BITS-1:0] f_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [ADDR_BITS-1:0] d_addr;
  logic [DATA_BITS-1:0] d_wdata;
  logic                 d_gnt;
  logic                 d_rvalid;
  logic [DATA_BITS-1:0] d_rdata;

  logic                 ram_rd_en;
  logic [ADDR_BITS-1:0] ram_rd_addr;
  logic [DATA_BITS-1:0] ram_rd_data;
  logic                 ram_wr_en;
  logic [ADDR_BITS-1:0] ram_wr_addr;
  logic [DATA_BITS-1:0] ram_wr_data;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_rd_data,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    output ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_rd_data,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    input  ram_rd_en, ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between fetch (read-only) and load/store through a one-stage access pipeline.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority, data over fetch.
module ram_arbiter #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input logic        clk,
  input logic        rst_n,
  ram_arbiter_if.slave bus
);

  logic grant_f;
  logic grant_d;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // 1 = data port was granted last; resets to "fetch last" so data wins the first contention.
  logic last_d_reg;

  always_comb begin
    grant_d = 1'b0;
    grant_f = 1'b0;
    if (bus.d_req && (!bus.f_req || !last_d_reg)) begin
      grant_d = 1'b1;
    end else if (bus.f_req) begin
      grant_f = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_reg <= 1'b0;
    end else if (grant_f || grant_d) begin
      last_d_reg <= grant_d;
    end
  end
`else
  always_comb begin
    grant_d = bus.d_req;
    grant_f = bus.f_req && !bus.d_req;
  end
`endif

  assign bus.f_gnt = grant_f;
  assign bus.d_gnt = grant_d;

  // Access stage: owner 0 = fetch, 1 = data.
  logic                 stg_valid_reg;
  logic                 stg_owner_reg;
  logic                 stg_we_reg;
  logic [ADDR_BITS-1:0] stg_addr_reg;
  logic [DATA_BITS-1:0] stg_wdata_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid_reg <= 1'b0;
      stg_owner_reg <= 1'b0;
      stg_we_reg    <= 1'b0;
      stg_addr_reg  <= '0;
      stg_wdata_reg <= '0;
    end else begin
      stg_valid_reg <= grant_f || grant_d;
      stg_owner_reg <= grant_d;
      stg_we_reg    <= grant_d && bus.d_we;
      if (grant_d) begin
        stg_addr_reg  <= bus.d_addr;
        stg_wdata_reg <= bus.d_wdata;
      end else if (grant_f) begin
        stg_addr_reg  <= bus.f_addr;
      end
    end
  end

  logic rd_fire;
  assign rd_fire = stg_valid_reg && !stg_we_reg;

  assign bus.ram_rd_en   = rd_fire;
  assign bus.ram_rd_addr = stg_addr_reg;
  assign bus.ram_wr_en   = stg_valid_reg && stg_we_reg;
  assign bus.ram_wr_addr = stg_addr_reg;
  assign bus.ram_wr_data = stg_wdata_reg;

  // Per-owner response registers; rdata holds until the same owner reads again.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic                 rvalid_reg;
    logic [DATA_BITS-1:0] rdata_reg;
    logic                 hit;

    assign hit = rd_fire && (stg_owner_reg == 1'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= hit;
        if (hit) begin
          rdata_reg <= bus.ram_rd_data;
        end
      end
    end
  end

  assign bus.f_rvalid = g_resp[0].rvalid_reg;
  assign bus.f_rdata  = g_resp[0].rdata_reg;
  assign bus.d_rvalid = g_resp[1].rvalid_reg;
  assign bus.d_rdata  = g_resp[1].rdata_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized self-checking bench for ram_arbiter; the reference model treats the RAM as sequential
// memory in grant order and expects read data two cycles after each grant.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8)) bus ();

  ram_arbiter #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM model: combinational read, write on posedge, plus a preload port used only during reset.
  logic [7:0] mem [256];
  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;

  assign bus.ram_rd_data = bus.ram_rd_en ? mem[bus.ram_rd_addr] : 'x;

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
  end

  typedef struct {
    bit         valid;
    bit         own_d;
    bit         we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] old;
  } txn_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [7:0] model_mem [256];
  txn_t       p1, p2;
  bit         last_d;
  logic [7:0] held_f, held_d;
  bit         mg_f, mg_d;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_model();
    p1.valid = 0; p1.own_d = 0; p1.we = 0; p1.addr = 0; p1.data = 0; p1.old = 0;
    p2 = p1;
    held_f = 0;
    held_d = 0;
    last_d = 0;
  endtask

  task automatic drive_idle();
    bus.f_req = 0; bus.f_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
  endtask

  // One bus cycle: drive requests, check pins/responses/grants against the model, advance the model.
  task automatic tick(input bit fr, input logic [7:0] fa, input bit dr, input bit dw,
                      input logic [7:0] da, input logic [7:0] dd);
    txn_t g;
    @(negedge clk);
    cyc++;
    bus.f_req = fr; bus.f_addr = fa;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
    #1;
    check_val("ram_rd_en", 32'(bus.ram_rd_en), 32'(p1.valid && !p1.we));
    check_val("ram_wr_en", 32'(bus.ram_wr_en), 32'(p1.valid && p1.we));
    if (p1.valid && !p1.we) check_val("ram_rd_addr", 32'(bus.ram_rd_addr), 32'(p1.addr));
    if (p1.valid && p1.we) begin
      check_val("ram_wr_addr", 32'(bus.ram_wr_addr), 32'(p1.addr));
      check_val("ram_wr_data", 32'(bus.ram_wr_data), 32'(p1.data));
    end
    if (p2.valid && !p2.we) begin
      if (p2.own_d) held_d = p2.data;
      else          held_f = p2.data;
    end
    check_val("f_rvalid", 32'(bus.f_rvalid), 32'(p2.valid && !p2.we && !p2.own_d));
    check_val("d_rvalid", 32'(bus.d_rvalid), 32'(p2.valid && !p2.we && p2.own_d));
    check_val("f_rdata", 32'(bus.f_rdata), 32'(held_f));
    check_val("d_rdata", 32'(bus.d_rdata), 32'(held_d));

    if (fr && dr) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      mg_d = !last_d;
`else
      mg_d = 1;
`endif
      mg_f = !mg_d;
    end else begin
      mg_d = dr;
      mg_f = fr;
    end
    check_val("f_gnt", 32'(bus.f_gnt), 32'(mg_f));
    check_val("d_gnt", 32'(bus.d_gnt), 32'(mg_d));

    g.valid = 0; g.own_d = 0; g.we = 0; g.addr = 0; g.data = 0; g.old = 0;
    if (mg_f || mg_d) begin
      last_d  = mg_d;
      g.valid = 1;
      g.own_d = mg_d;
      g.we    = mg_d && dw;
      g.addr  = mg_d ? da : fa;
      if (g.we) begin
        g.data = dd;
        g.old  = model_mem[g.addr];
        model_mem[g.addr] = dd;
      end else begin
        g.data = model_mem[g.addr];
      end
      $display("cycle %0d: grant %s %s addr=%02h data=%02h", cyc, mg_d ? "D" : "F",
               g.we ? "WR" : "RD", g.addr, g.data);
    end
    p2 = p1;
    p1 = g;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  bit         fp, dp, dwr;
  logic [7:0] fad, dad, dwd;
  int         kf, kd;

  initial begin
    rst_n = 1'b1;
    load_en = 0; load_addr = 0; load_data = 0;
    drive_idle();
    clear_model();
    #2 rst_n = 1'b0;

    // Preload the RAM while the arbiter is held in reset.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      load_en   = 1;
      load_addr = 8'(i);
      load_data = (i == 8'h10) ? 8'hA5 : (i == 8'h30) ? 8'h11 : 8'($urandom);
      model_mem[i] = load_data;
    end
    @(negedge clk);
    load_en = 0;
    #1;
    check_val("rst_ram_rd_en", 32'(bus.ram_rd_en), 32'd0);
    check_val("rst_ram_wr_en", 32'(bus.ram_wr_en), 32'd0);
    check_val("rst_ram_wr_addr", 32'(bus.ram_wr_addr), 32'd0);
    check_val("rst_ram_wr_data", 32'(bus.ram_wr_data), 32'd0);
    check_val("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
    check_val("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    idle(10);

    // Single fetch read of the preloaded 0xA5.
    tick(1, 8'h10, 0, 0, 8'h00, 8'h00);
    idle(3);
    check_val("fetch_a5", 32'(bus.f_rdata), 32'hA5);

    // Data write then read-after-write at the same address.
    tick(0, 8'h00, 1, 1, 8'h20, 8'h3C);
    tick(0, 8'h00, 1, 0, 8'h20, 8'h00);
    idle(3);
    check_val("raw_3c", 32'(bus.d_rdata), 32'h3C);

    // Write granted, then reset pulsed during its access cycle.
    tick(0, 8'h00, 1, 1, 8'h30, 8'h77);
    @(negedge clk);
    cyc++;
    drive_idle();
    #1;
    check_val("mid_wr_en_before", 32'(bus.ram_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_wr_en_after", 32'(bus.ram_wr_en), 32'd0);
    check_val("mid_rd_en", 32'(bus.ram_rd_en), 32'd0);
    check_val("mid_d_rdata", 32'(bus.d_rdata), 32'd0);
    check_val("mid_f_rdata", 32'(bus.f_rdata), 32'd0);
    if (p1.valid && p1.we) model_mem[p1.addr] = p1.old;
    clear_model();
    @(posedge clk);
    #1;
    check_val("mid_ram_kept", 32'(mem[8'h30]), 32'h11);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    tick(1, 8'h30, 0, 0, 8'h00, 8'h00);
    idle(3);

    // Continuous contention for 6 cycles, distinct read addresses per port.
    kf = 0;
    kd = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1, 8'(8'h40 + kf), 1, 0, 8'(8'h50 + kd), 8'h00);
      if (mg_f) kf++;
      if (mg_d) kd++;
    end
    idle(3);

    // Random traffic: requests held until granted, occasionally dropped.
    fp = 0; dp = 0; dwr = 0; fad = 0; dad = 0; dwd = 0;
    for (int i = 0; i < 400; i++) begin
      if (fp && $urandom_range(0, 19) == 0) fp = 0;
      else if (!fp && $urandom_range(0, 9) < 6) begin
        fp  = 1;
        fad = 8'($urandom_range(0, 15));
      end
      if (dp && $urandom_range(0, 19) == 0) dp = 0;
      else if (!dp && $urandom_range(0, 9) < 6) begin
        dp  = 1;
        dwr = 1'($urandom_range(0, 1));
        dad = 8'($urandom_range(0, 15));
        dwd = 8'($urandom);
      end
      tick(fp, fad, dp, dwr, dad, dwd);
      if (mg_f) fp = 0;
      if (mg_d) dp = 0;
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
